trigger_capture_fifo_inf_c: RTL

TRIGGER_CAPTURE_FIFO_INF_C -- requirements
Module: trigger_capture_fifo_inf_c

---
 rtl/trigger_capture_fifo_inf_c_if.sv | 20 ++
 rtl/trigger_capture_fifo_inf_c.sv | 84 ++++++++
 2 files changed

// File: rtl/trigger_capture_fifo_inf_c_if.sv
// data_inf_c: valid/ready/data stream interface that also carries the clock
// and the active-low asynchronous reset.
//   clock  - stream clock; all state updates on its rising edge
//   rst_n  - asynchronous active-low reset
//   valid  - producer has a word on data
//   ready  - consumer accepts the word this cycle
//   data   - payload, DSIZE bits
interface data_inf_c #(
  parameter int DSIZE = 32
) (
  input logic clock,
  input logic rst_n
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (input clock, input rst_n, input ready, output valid, output data);
  modport slave  (input clock, input rst_n, input valid, input data, output ready);
endinterface

// File: rtl/trigger_capture_fifo_inf_c.sv
// trigger_capture_fifo_inf_c: captures `data` on every cycle `trigger` is
// high into a first-word-fall-through FIFO and streams it out on out_inf.
// A trigger that finds the FIFO full, with no pop in the same cycle, is
// dropped: overflow pulses for one cycle and drop_cnt counts (saturating).
//   trigger   - capture request, one capture per high cycle
//   data      - value sampled on a trigger cycle
//   out_inf   - master side of the output stream; supplies clock and rst_n
//   overflow  - one-cycle pulse for each dropped trigger
//   drop_cnt  - saturating count of dropped triggers
//   level     - current FIFO occupancy, 0..DEPTH
module trigger_capture_fifo_inf_c #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   trigger,
  input  logic [DSIZE-1:0]       data,
  data_inf_c.master              out_inf,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if ($bits(out_inf.data) != DSIZE || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("trigger_capture_fifo_inf_c: DSIZE must match out_inf and DEPTH must be a power of 2 >= 2");
  end

  logic             clk;
  logic             rst_n;
  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             push;
  logic             pop;

  assign clk   = out_inf.clock;
  assign rst_n = out_inf.rst_n;

  // A full FIFO still accepts a trigger when the head leaves in the same
  // cycle; that is the only path by which ready influences capture.
  assign pop  = out_inf.valid && out_inf.ready;
  assign push = trigger && ((level < LW'(DEPTH)) || pop);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      out_inf.valid <= 1'b0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of 2, so the
      // increment wraps DEPTH-1 -> 0 on its own.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level         <= level_nxt;
      out_inf.valid <= (level_nxt != '0);
      overflow      <= trigger && !push;
      if (trigger && !push && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Storage is not reset; stale words are never visible because valid is.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  assign out_inf.data = mem[rd_ptr];

endmodule
